datapath_controller: RTL
========================

Name: datapath_controller

Overview:
- Control unit that sits opposite the datapath: it consumes `current_instruction` and the per-register flag vectors, and drives every datapath control input.
- Multi-cycle FSM: FETCH, then EXEC, plus wait states for memory load and VGA plot.
- Register 0 is the program counter and is only advanced through datapath controls.
- Also owns a plot handshake toward the VGA adapter, plus halt and fault status.

Parameters:
- `IW`, 16: instruction and data width.
- `PLOT_TIMEOUT`, 255: maximum cycles to wait for `vga_ack` before faulting.

Ports:
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `current_instruction`  in  16  instruction word at PC from the datapath.
- `zeroflag`  in  16  zero flag per register (bit i = register i).
- `signflag`  in  16  sign flag per register.
- `vga_ack`  in  1  VGA adapter accepted the plot.
- `program_counter_increment`  out  1  add 1 to register 0 this edge.
- `alu_op`  out  4  ALU operation.
- `alu_a_select`, `alu_b_select`  out  4  source register indices.
- `alu_a_source`, `alu_b_source`  out  1  0 = register, 1 = altern.
- `alu_a_altern`, `alu_b_altern`  out  16  immediate operands.
- `alu_out_select`  out  4  destination register.
- `alu_load_src`  out  2  register write source.
- `alu_store_to_mem`, `alu_store_to_stk`  out  1  store strobes.
- `vga_color_select`, `vga_coord_select`  out  4  VGA source registers.
- `vga_plot`  out  1  plot request.
- `halted`  out  1  HALT state.
- `fault`  out  1  FAULT state.

Behaviour:
- Instruction fields: `op=[15:12]`, `rd=[11:8]`, `ra=[7:4]`, `rb=[3:0]`, `imm8=[7:0]`.
- `alu_load_src` encoding: 00 no write, 01 ALU result, 10 memory data, 11 reserved (never driven).
- Reset (async, `resetn=0`): state=FETCH, `ir`=0, timeout counter=0. Every output is 0; selects are 0 and alterns are 0.
- Idle defaults, in any state unless stated otherwise: all outputs 0.
- FETCH: idle outputs for 1 cycle while instruction memory reads. Next state EXEC.
- EXEC: decode `current_instruction` and latch it into `ir`. Outputs per opcode; unless stated, PC inc=1, next=FETCH:
  - 0 NOP: no write.
  - 1 ADDI: `alu_op`=1, a=`rd`, `b_source`=1, `b_altern`={8'h0,`imm8`}, out=`rd`, load=01.
  - 2 ADD / 3 SUB: `alu_op`=1 / 2, a=`ra`, b=`rb`, out=`rd`, load=01.
  - 4 MOV: `alu_op`=0, a=`ra`, out=`rd`, load=01.
  - 5 JMP: `alu_op`=0, a=`ra`, out=0, load=01, PC inc=0.
  - 6 BZ: if `zeroflag[rd]` then behave as JMP with a=`ra`; else NOP.
  - 7 BN: same as BZ, using `signflag[rd]`.
  - 8 ST: `alu_op`=0, a=`ra` (address), b=`rb` (data), `store_to_mem`=1.
  - 9 LD: `alu_op`=0, a=`ra`, load=00, PC inc=0, next=MEMWAIT.
  - A PUSH: a=`ra`, `store_to_stk`=1.
  - B PLOT: `vga_color_select`=`ra`, `vga_coord_select`=`rb`, `vga_plot`=1, PC inc=0, next=PLOTWAIT, counter cleared.
  - F HALT: PC inc=0, next=HALT.
  - C, D, E: next=FAULT, no write, PC inc=0.
- MEMWAIT (1 cycle): decode from `ir`. a=`ir.ra`, load=10, out=`ir.rd`, PC inc=1. Next=FETCH.
- PLOTWAIT: hold the selects from `ir` and `vga_plot`=1.
  - `vga_ack`=1: `vga_plot`=0 that cycle, PC inc=1, next=FETCH.
  - Otherwise the counter increments. Reaching `PLOT_TIMEOUT` without ack: next=FAULT.
  - `vga_ack` already high on EXEC entry is accepted on the first PLOTWAIT cycle.
- HALT, FAULT: absorbing until reset. `halted` or `fault` = 1, all other outputs idle.
- Ops that write `rd`=0 with PC inc=1 produce target+1. This is legal and intended.
- Reset asserted mid-LD or mid-PLOT: abandon immediately, `vga_plot` drops asynchronously.

Decomposition:
- Package `datapath_pkg`:
  - opcode constants (OP_NOP..OP_HALT);
  - ALU op constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2);
  - LOAD_NONE/ALU/MEM encodings;
  - state enum (FETCH, EXEC, MEMWAIT, PLOTWAIT, HALT, FAULT).
- One natural sub-module: `instr_decoder`, a combinational map from instruction and flags to the control bundle. The FSM muxes it against the idle values.

Test Plan:
- Reset, then `current_instruction`=16'h1702 (ADDI r7,2) → EXEC cycle: `alu_op`=1, a=7, `b_altern`=2, out=7, load=01, PC inc=1; next cycle FETCH with all outputs 0.
- Instruction 16'h5070 (JMP r7) → out=0, load=01, PC inc=0, a=7. Instruction 16'h6175 with `zeroflag[1]`=0 → load=00, PC inc=1.
- LD 16'h9340 → EXEC: load=00, PC inc=0. MEMWAIT: load=10, out=3, PC inc=1, even if `current_instruction` changes during MEMWAIT.
- PLOT 16'hB012 with `vga_ack` held low 3 cycles then high → `vga_plot`=1 for 4 cycles, `vga_color_select`=1, `vga_coord_select`=2, then FETCH. With `PLOT_TIMEOUT`=4 and ack never high → `fault`=1.
- Opcode 16'hC000 → `fault`=1 and outputs frozen idle. 16'hF000 → `halted`=1. Deassert then reassert `resetn` → FETCH with all outputs 0.
- `resetn` pulsed low mid-PLOTWAIT → `vga_plot` drops before the next clock edge, and the controller restarts in FETCH.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the datapath control unit.
// Opcodes, ALU ops, write-source codes, FSM states and control bundle.
package datapath_pkg;

    localparam int DW = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_BZ   = 4'h6;
    localparam logic [3:0] OP_BN   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_PUSH = 4'hA;
    localparam logic [3:0] OP_PLOT = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;

    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_MEM  = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEMWAIT,
        PLOTWAIT,
        HALT,
        FAULT
    } state_t;

    typedef struct packed {
        logic          pc_inc;
        logic [3:0]    alu_op;
        logic [3:0]    a_sel;
        logic [3:0]    b_sel;
        logic          a_src;
        logic          b_src;
        logic [DW-1:0] a_alt;
        logic [DW-1:0] b_alt;
        logic [3:0]    out_sel;
        logic [1:0]    load_src;
        logic          st_mem;
        logic          st_stk;
        logic [3:0]    color_sel;
        logic [3:0]    coord_sel;
        logic          plot;
        logic          halted;
        logic          fault;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// Combinational decode of one instruction word into the control bundle.
// Also reports which state the controller should enter after EXEC.
module instr_decoder
    import datapath_pkg::*;
(
    input  logic [DW-1:0] instr,
    input  logic [DW-1:0] zeroflag,
    input  logic [DW-1:0] signflag,
    output ctrl_t         ctrl,
    output state_t        next_state
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       taken;

    assign op = instr[15:12];
    assign rd = instr[11:8];
    assign ra = instr[7:4];
    assign rb = instr[3:0];

    always_comb begin
        ctrl       = CTRL_IDLE;
        next_state = FETCH;
        taken      = 1'b0;
        unique case (op)
            OP_NOP: ctrl.pc_inc = 1'b1;
            OP_ADDI: begin
                ctrl.alu_op   = ALU_ADD;
                ctrl.a_sel    = rd;
                ctrl.b_src    = 1'b1;
                ctrl.b_alt    = {8'h00, instr[7:0]};
                ctrl.out_sel  = rd;
                ctrl.load_src = LOAD_ALU;
                ctrl.pc_inc   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                ctrl.alu_op   = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
                ctrl.a_sel    = ra;
                ctrl.b_sel    = rb;
                ctrl.out_sel  = rd;
                ctrl.load_src = LOAD_ALU;
                ctrl.pc_inc   = 1'b1;
            end
            OP_MOV: begin
                ctrl.alu_op   = ALU_PASS;
                ctrl.a_sel    = ra;
                ctrl.out_sel  = rd;
                ctrl.load_src = LOAD_ALU;
                ctrl.pc_inc   = 1'b1;
            end
            OP_JMP: begin
                ctrl.a_sel    = ra;
                ctrl.load_src = LOAD_ALU;
            end
            // A taken branch is a jump into r0; untaken falls through.
            OP_BZ, OP_BN: begin
                taken = (op == OP_BZ) ? zeroflag[rd] : signflag[rd];
                if (taken) begin
                    ctrl.a_sel    = ra;
                    ctrl.load_src = LOAD_ALU;
                end else begin
                    ctrl.pc_inc = 1'b1;
                end
            end
            OP_ST: begin
                ctrl.a_sel  = ra;
                ctrl.b_sel  = rb;
                ctrl.st_mem = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            OP_LD: begin
                ctrl.a_sel = ra;
                next_state = MEMWAIT;
            end
            OP_PUSH: begin
                ctrl.a_sel  = ra;
                ctrl.st_stk = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            OP_PLOT: begin
                ctrl.color_sel = ra;
                ctrl.coord_sel = rb;
                ctrl.plot      = 1'b1;
                next_state     = PLOTWAIT;
            end
            OP_HALT: next_state = HALT;
            default: next_state = FAULT;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle control FSM driving the datapath and the VGA plot port.
// Outputs are decoded from the state register so reset clears them at once.
module datapath_controller
    import datapath_pkg::*;
#(
    parameter int IW           = 16,
    parameter int PLOT_TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [IW-1:0] current_instruction,
    input  logic [IW-1:0] zeroflag,
    input  logic [IW-1:0] signflag,
    input  logic          vga_ack,
    output logic          program_counter_increment,
    output logic [3:0]    alu_op,
    output logic [3:0]    alu_a_select,
    output logic [3:0]    alu_b_select,
    output logic          alu_a_source,
    output logic          alu_b_source,
    output logic [IW-1:0] alu_a_altern,
    output logic [IW-1:0] alu_b_altern,
    output logic [3:0]    alu_out_select,
    output logic [1:0]    alu_load_src,
    output logic          alu_store_to_mem,
    output logic          alu_store_to_stk,
    output logic [3:0]    vga_color_select,
    output logic [3:0]    vga_coord_select,
    output logic          vga_plot,
    output logic          halted,
    output logic          fault
);

    localparam int CW = $clog2(PLOT_TIMEOUT + 1);

    state_t        state;
    state_t        dec_next;
    logic [11:0]   ir;
    logic [CW-1:0] cnt;
    ctrl_t         dec;
    ctrl_t         ctrl;

    instr_decoder u_dec (
        .instr      (current_instruction),
        .zeroflag   (zeroflag),
        .signflag   (signflag),
        .ctrl       (dec),
        .next_state (dec_next)
    );

    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            EXEC: ctrl = dec;
            MEMWAIT: begin
                ctrl.a_sel    = ir[7:4];
                ctrl.out_sel  = ir[11:8];
                ctrl.load_src = LOAD_MEM;
                ctrl.pc_inc   = 1'b1;
            end
            PLOTWAIT: begin
                ctrl.color_sel = ir[7:4];
                ctrl.coord_sel = ir[3:0];
                ctrl.plot      = ~vga_ack;
                ctrl.pc_inc    = vga_ack;
            end
            HALT:  ctrl.halted = 1'b1;
            FAULT: ctrl.fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= FETCH;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    ir    <= current_instruction[11:0];
                    cnt   <= '0;
                    state <= dec_next;
                end
                MEMWAIT: state <= FETCH;
                PLOTWAIT: begin
                    if (vga_ack)
                        state <= FETCH;
                    else if (cnt == CW'(PLOT_TIMEOUT - 1))
                        state <= FAULT;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign program_counter_increment = ctrl.pc_inc;
    assign alu_op           = ctrl.alu_op;
    assign alu_a_select     = ctrl.a_sel;
    assign alu_b_select     = ctrl.b_sel;
    assign alu_a_source     = ctrl.a_src;
    assign alu_b_source     = ctrl.b_src;
    assign alu_a_altern     = ctrl.a_alt;
    assign alu_b_altern     = ctrl.b_alt;
    assign alu_out_select   = ctrl.out_sel;
    assign alu_load_src     = ctrl.load_src;
    assign alu_store_to_mem = ctrl.st_mem;
    assign alu_store_to_stk = ctrl.st_stk;
    assign vga_color_select = ctrl.color_sel;
    assign vga_coord_select = ctrl.coord_sel;
    assign vga_plot         = ctrl.plot;
    assign halted           = ctrl.halted;
    assign fault            = ctrl.fault;

endmodule
